// File: rtl/sr_mem_sched.sv
// sr_mem_sched
// Sequencer for one MEM2048X24 pixel buffer in the bilinear super-resolution
// datapath. The buffer is a circular store: one writer appends pixels at
// wr_ptr, the consumer frees the oldest pixels with release commands, and two
// interpolation requesters share the single read port through round-robin
// arbitration.
//
// Ports
//   CK, RST              clock (rising edge) and asynchronous active-high reset
//   en                   run enable (IDLE <-> RUN)
//   flush                one-cycle pulse, discards every buffered pixel
//   wr_valid/ready/data  pixel write stream
//   rq_valid, rq_addr0/1 read requests with absolute buffer addresses
//   rq_ready             one-hot combinational grant
//   rsp_valid/id/err/data read response, one cycle after the grant
//   rel_valid, rel_cnt   free the rel_cnt oldest pixels (clamped to count)
//   count, base_ptr      occupancy and address of the oldest pixel
//   MEM_*                memory macro controls; MEM_D_OUT valid 1 cycle after MEM_RE
module sr_mem_sched #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 24
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          en,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    rq_valid,
    input  logic [AW-1:0] rq_addr0,
    input  logic [AW-1:0] rq_addr1,
    output logic [1:0]    rq_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_data,
    input  logic          rel_valid,
    input  logic [AW:0]   rel_cnt,
    output logic [AW:0]   count,
    output logic [AW-1:0] base_ptr,
    output logic          MEM_CS,
    output logic          MEM_WEB,
    output logic          MEM_RE,
    output logic [AW-1:0] MEM_W_ADDR,
    output logic [AW-1:0] MEM_R_ADDR,
    output logic [DW-1:0] MEM_D_IN,
    input  logic [DW-1:0] MEM_D_OUT
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] base_ptr_reg;
    logic [AW:0]   count_reg;
    logic          last_gnt_reg;
    logic          rsp_pending_reg;
    logic          rsp_id_reg;
    logic          rsp_hit_reg;

    logic          run;
    logic          wr_acc;
    logic [AW-1:0] rq_addr_arr [2];
    logic [1:0]    hit_vec;
    logic [1:0]    gnt_vec;
    logic          gnt_any;
    logic          gnt_id;
    logic          gnt_hit;
    logic          mem_re;
    logic [AW-1:0] gnt_addr;
    logic [AW:0]   rel_eff;
    logic [AW:0]   count_next;
    logic [AW-1:0] base_ptr_next;
    logic [AW-1:0] wr_ptr_next;

    assign run            = (state_reg == ST_RUN);
    assign rq_addr_arr[0] = rq_addr0;
    assign rq_addr_arr[1] = rq_addr1;

    // Window check per requester: the distance from the oldest pixel, taken
    // modulo DEPTH by the natural AW-bit wrap, must be below the occupancy.
    // The pre-update count is used, so a pixel written this cycle is not yet
    // readable.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_win
            logic [AW-1:0] offset;
            assign offset      = rq_addr_arr[gi] - base_ptr_reg;
            assign hit_vec[gi] = ({1'b0, offset} < count_reg);
        end
    endgenerate

    // Round-robin: under contention the requester that was not granted last
    // wins. last_gnt resets to 1 so the first contention goes to requester 0.
    always_comb begin
        gnt_vec = 2'b00;
        if (run) begin
            case (rq_valid)
                2'b01:   gnt_vec = 2'b01;
                2'b10:   gnt_vec = 2'b10;
                2'b11:   gnt_vec = last_gnt_reg ? 2'b01 : 2'b10;
                default: gnt_vec = 2'b00;
            endcase
        end
    end

    assign gnt_any  = |gnt_vec;
    assign gnt_id   = gnt_vec[1];
    assign gnt_hit  = hit_vec[gnt_id];
    assign gnt_addr = rq_addr_arr[gnt_id];
    assign mem_re   = gnt_any & gnt_hit;

    assign wr_ready = run & (count_reg != FULL_CNT);
    assign wr_acc   = wr_valid & wr_ready;

    // A release never frees more than is currently held.
    always_comb begin
        rel_eff = '0;
        if (run && rel_valid) begin
            rel_eff = (rel_cnt < count_reg) ? rel_cnt : count_reg;
        end
    end

    assign count_next    = count_reg + {{AW{1'b0}}, wr_acc} - rel_eff;
    assign base_ptr_next = base_ptr_reg + rel_eff[AW-1:0];
    assign wr_ptr_next   = wr_ptr_reg + {{(AW-1){1'b0}}, wr_acc};

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            base_ptr_reg    <= '0;
            count_reg       <= '0;
            last_gnt_reg    <= 1'b1;
            rsp_pending_reg <= 1'b0;
            rsp_id_reg      <= 1'b0;
            rsp_hit_reg     <= 1'b0;
        end else begin
            if (flush) begin
                state_reg    <= ST_FLUSH;
                wr_ptr_reg   <= '0;
                base_ptr_reg <= '0;
                count_reg    <= '0;
            end else begin
                state_reg    <= en ? ST_RUN : ST_IDLE;
                wr_ptr_reg   <= wr_ptr_next;
                base_ptr_reg <= base_ptr_next;
                count_reg    <= count_next;
            end
            if (gnt_any) begin
                last_gnt_reg <= gnt_id;
            end
            // Response bookkeeping survives a flush so a grant made in the
            // pulse cycle is still answered during the FLUSH cycle.
            rsp_pending_reg <= gnt_any;
            rsp_id_reg      <= gnt_id;
            rsp_hit_reg     <= gnt_hit;
        end
    end

    assign rq_ready  = gnt_vec;
    assign rsp_valid = rsp_pending_reg;
    assign rsp_id    = rsp_pending_reg & rsp_id_reg;
    assign rsp_err   = rsp_pending_reg & ~rsp_hit_reg;
    // Memory output is only passed through on a hit so X never escapes.
    assign rsp_data  = (rsp_pending_reg && rsp_hit_reg) ? MEM_D_OUT : '0;

    assign count      = count_reg;
    assign base_ptr   = base_ptr_reg;
    assign MEM_WEB    = wr_acc;
    assign MEM_RE     = mem_re;
    assign MEM_CS     = wr_acc | mem_re;
    assign MEM_W_ADDR = wr_acc ? wr_ptr_reg : '0;
    assign MEM_D_IN   = wr_acc ? wr_data : '0;
    assign MEM_R_ADDR = mem_re ? gnt_addr : '0;

endmodule

// File: tb/tb_sr_mem_sched.sv
// Testbench for sr_mem_sched: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural buffer model.
module tb_sr_mem_sched;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int DW    = 24;

    logic          CK = 1'b0;
    logic          RST;
    logic          en, flush, wr_valid, rel_valid;
    logic [DW-1:0] wr_data;
    logic [1:0]    rq_valid;
    logic [AW-1:0] rq_addr0, rq_addr1;
    logic [AW:0]   rel_cnt;
    logic          wr_ready, rsp_valid, rsp_id, rsp_err;
    logic [1:0]    rq_ready;
    logic [DW-1:0] rsp_data;
    logic [AW:0]   count;
    logic [AW-1:0] base_ptr;
    logic          MEM_CS, MEM_WEB, MEM_RE;
    logic [AW-1:0] MEM_W_ADDR, MEM_R_ADDR;
    logic [DW-1:0] MEM_D_IN, MEM_D_OUT;

    sr_mem_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CK(CK), .RST(RST), .en(en), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rq_valid(rq_valid), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rel_valid(rel_valid), .rel_cnt(rel_cnt),
        .count(count), .base_ptr(base_ptr),
        .MEM_CS(MEM_CS), .MEM_WEB(MEM_WEB), .MEM_RE(MEM_RE),
        .MEM_W_ADDR(MEM_W_ADDR), .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_D_IN(MEM_D_IN), .MEM_D_OUT(MEM_D_OUT)
    );

    always #5 CK = ~CK;

    // MEM2048X24 stand-in: synchronous write, one-cycle registered read.
    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] mem_q;
    always @(posedge CK) begin
        if (MEM_CS && MEM_WEB) mem_arr[MEM_W_ADDR] <= MEM_D_IN;
        if (MEM_CS && MEM_RE)  mem_q <= mem_arr[MEM_R_ADDR];
    end
    assign MEM_D_OUT = mem_q;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 run, 2 flush; pixels stored by absolute address.
    int            m_state, m_wr, m_base, m_count, m_last;
    bit            m_pend, m_perr;
    int            m_pid;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] px [DEPTH];

    task automatic model_reset();
        m_state = 0; m_wr = 0; m_base = 0; m_count = 0; m_last = 1;
        m_pend = 0; m_perr = 0; m_pid = 0; m_pdata = '0;
    endtask

    task automatic drive_quiet();
        flush = 0; wr_valid = 0; wr_data = '0; rq_valid = 2'b00;
        rq_addr0 = '0; rq_addr1 = '0; rel_valid = 0; rel_cnt = '0;
    endtask

    // Compare every output against the model for the current inputs, then
    // advance the model across the coming clock edge.
    task automatic model_step();
        bit run, wr_acc, granted, hit;
        int g, addr, eff;
        logic [1:0] exp_gnt;
        run     = (m_state == 1);
        wr_acc  = run && (m_count != DEPTH) && wr_valid;
        granted = run && (rq_valid != 2'b00);
        if (rq_valid == 2'b11) g = 1 - m_last;
        else                   g = (rq_valid == 2'b10) ? 1 : 0;
        exp_gnt = granted ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
        addr    = (g == 1) ? int'(rq_addr1) : int'(rq_addr0);
        hit     = (((addr - m_base + DEPTH) % DEPTH) < m_count);

        check("wr_ready", wr_ready, run && (m_count != DEPTH));
        check("rq_ready", rq_ready, exp_gnt);
        check("mem_web", MEM_WEB, wr_acc);
        check("mem_re", MEM_RE, granted && hit);
        check("mem_cs", MEM_CS, wr_acc || (granted && hit));
        if (wr_acc) begin
            check("mem_w_addr", MEM_W_ADDR, m_wr);
            check("mem_d_in", MEM_D_IN, wr_data);
        end
        if (granted && hit) check("mem_r_addr", MEM_R_ADDR, addr);
        check("rsp_valid", rsp_valid, m_pend);
        if (m_pend) begin
            check("rsp_id", rsp_id, m_pid);
            check("rsp_err", rsp_err, m_perr);
        end
        check("rsp_data", rsp_data, m_pend ? m_pdata : '0);
        check("count", count, m_count);
        check("base_ptr", base_ptr, m_base);

        eff = 0;
        if (run && rel_valid) eff = (int'(rel_cnt) < m_count) ? int'(rel_cnt) : m_count;
        m_pend  = granted;
        m_pid   = g;
        m_perr  = !hit;
        m_pdata = hit ? px[addr] : '0;
        if (granted) m_last = g;
        if (wr_acc) begin
            px[m_wr] = wr_data;
            m_wr = (m_wr + 1) % DEPTH;
        end
        m_base  = (m_base + eff) % DEPTH;
        m_count = m_count + int'(wr_acc) - eff;
        if (flush) begin
            m_state = 2; m_wr = 0; m_base = 0; m_count = 0;
        end else begin
            m_state = en ? 1 : 0;
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        #4;
        model_step();
        @(posedge CK);
        #1;
    endtask

    task automatic check_all_zero();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rq_ready", rq_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_count", count, 0);
        check("rst_base_ptr", base_ptr, 0);
        check("rst_mem_cs", MEM_CS, 0);
        check("rst_mem_web", MEM_WEB, 0);
        check("rst_mem_re", MEM_RE, 0);
        check("rst_mem_w_addr", MEM_W_ADDR, 0);
        check("rst_mem_r_addr", MEM_R_ADDR, 0);
        check("rst_mem_d_in", MEM_D_IN, 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        RST = 1;
        #1;
        check_all_zero();
        model_reset();
        drive_quiet();
        en = 0;
        @(posedge CK);
        #1;
        RST = 0;
    endtask

    task automatic start_run();
        async_reset();
        en = 1;
        cycle();
    endtask

    task automatic write_px(input logic [DW-1:0] d);
        wr_valid = 1; wr_data = d;
        cycle();
        wr_valid = 0;
    endtask

    initial begin
        RST = 1; en = 0;
        drive_quiet();
        model_reset();
        #1;
        check_all_zero();
        @(posedge CK);
        #1;
        RST = 0;

        // Five pixels, then a read of address 2.
        en = 1;
        cycle();
        for (int i = 1; i <= 5; i++) write_px(DW'(i));
        rq_valid = 2'b01; rq_addr0 = 11'd2;
        cycle();
        rq_valid = 2'b00;
        check("tp1_rsp_data", rsp_data, 24'h000003);
        check("tp1_rsp_err", rsp_err, 0);
        cycle();

        // Fill to DEPTH, attempt one more, release 4, wrap write.
        start_run();
        for (int i = 0; i < DEPTH; i++) write_px(DW'($urandom));
        check("full_count", count, DEPTH);
        wr_valid = 1; wr_data = 24'h123456;
        cycle();
        wr_valid = 0;
        rel_valid = 1; rel_cnt = 12'd4;
        cycle();
        rel_valid = 0;
        check("rel4_base", base_ptr, 4);
        write_px(24'hABCDEF);
        check("wrap_count", count, 2045);
        rq_valid = 2'b10; rq_addr1 = 11'd0;
        cycle();
        rq_valid = 2'b00;
        check("wrap_rsp_data", rsp_data, 24'hABCDEF);
        cycle();

        // Contention from reset: grants alternate starting with 0.
        start_run();
        rq_valid = 2'b11;
        for (int i = 0; i < 4; i++) cycle();
        rq_valid = 2'b00;
        cycle();

        // Window edge: count=3, address 3 misses, address 2 hits.
        start_run();
        for (int i = 0; i < 3; i++) write_px(DW'(24'h100 + i));
        rq_valid = 2'b01; rq_addr0 = 11'd3;
        cycle();
        check("win_miss_err", rsp_err, 1);
        rq_addr0 = 11'd2;
        cycle();
        rq_valid = 2'b00;
        check("win_hit_err", rsp_err, 0);
        cycle();

        // Over-release clamps; same-cycle write and release at count=1.
        start_run();
        for (int i = 0; i < 10; i++) write_px(DW'(i));
        rel_valid = 1; rel_cnt = 12'd100;
        cycle();
        rel_valid = 0;
        check("clamp_count", count, 0);
        check("clamp_base", base_ptr, 10);
        write_px(24'h55);
        wr_valid = 1; wr_data = 24'h66; rel_valid = 1; rel_cnt = 12'd1;
        cycle();
        wr_valid = 0; rel_valid = 0;
        check("wr_rel_count", count, 1);
        cycle();

        // Flush with both requesters pending at count=7.
        start_run();
        for (int i = 0; i < 7; i++) write_px(DW'(24'h700 + i));
        rq_valid = 2'b11; rq_addr0 = 11'd1; rq_addr1 = 11'd4; flush = 1;
        cycle();
        flush = 0;
        cycle();
        check("flush_count", count, 0);
        check("flush_base", base_ptr, 0);
        rq_valid = 2'b00;
        cycle();

        // Reset in the middle of a write/read burst.
        start_run();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1; wr_data = DW'($urandom);
            rq_valid = 2'b11; rq_addr0 = AW'(i); rq_addr1 = 11'd0;
            cycle();
        end
        async_reset();

        // Randomized traffic.
        en = 1;
        for (int n = 0; n < 4000; n++) begin
            en        = ($urandom_range(0, 19) != 0);
            flush     = ($urandom_range(0, 149) == 0);
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_data   = DW'($urandom);
            rq_valid  = 2'($urandom_range(0, 3));
            rq_addr0  = AW'((m_base + $urandom_range(0, m_count + 3)) % DEPTH);
            rq_addr1  = AW'((m_base + $urandom_range(0, m_count + 3)) % DEPTH);
            rel_valid = ($urandom_range(0, 3) == 0);
            rel_cnt   = ($urandom_range(0, 49) == 0) ? 12'($urandom_range(0, 4095))
                                                      : 12'($urandom_range(0, 6));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                en = 1;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
